// File: rtl/lsu_ctrl_if.sv
// Load/store unit bus bundle: execute-stage request, data-memory port and results.
// The slave modport is the LSU itself; master is whatever surrounds it (pipeline + memory).
interface lsu_ctrl_if;
    logic        mem_valid;
    logic [5:0]  alucode;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] load_data;
    logic        done;
    logic        stall;
    logic        misalign;
    logic        bus_err;

    modport master (
        output mem_valid, alucode, addr, store_data, dmem_ack, dmem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
               load_data, done, stall, misalign, bus_err
    );

    modport slave (
        input  mem_valid, alucode, addr, store_data, dmem_ack, dmem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
               load_data, done, stall, misalign, bus_err
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between execute stage and a variable-latency data memory.
// Optional REQ timeout with bus error pulse is enabled by defining LSU_TIMEOUT_EN.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    lsu_ctrl_if.slave  bus
);
    localparam logic [5:0] ALU_LB  = 6'd9;
    localparam logic [5:0] ALU_LH  = 6'd10;
    localparam logic [5:0] ALU_LW  = 6'd11;
    localparam logic [5:0] ALU_LBU = 6'd12;
    localparam logic [5:0] ALU_LHU = 6'd13;
    localparam logic [5:0] ALU_SB  = 6'd14;
    localparam logic [5:0] ALU_SH  = 6'd15;
    localparam logic [5:0] ALU_SW  = 6'd16;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t      r_state;
    logic        r_dmem_req;
    logic        r_dmem_we;
    logic [31:0] r_dmem_addr;
    logic [3:0]  r_dmem_be;
    logic [31:0] r_dmem_wdata;
    logic [31:0] r_load_data;
    logic        r_done;
    logic        r_misalign;
    logic [1:0]  r_off;
    logic        r_is_load;

    logic        w_is_mem;
    logic        w_is_store;
    size_t       w_size;
    logic        w_misaligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_is_mem   = 1'b1;
        w_is_store = 1'b0;
        w_size     = SZ_W;
        case (bus.alucode)
            ALU_LB, ALU_LBU: w_size = SZ_B;
            ALU_LH, ALU_LHU: w_size = SZ_H;
            ALU_LW:          w_size = SZ_W;
            ALU_SB:          begin w_size = SZ_B; w_is_store = 1'b1; end
            ALU_SH:          begin w_size = SZ_H; w_is_store = 1'b1; end
            ALU_SW:          begin w_size = SZ_W; w_is_store = 1'b1; end
            default:         w_is_mem = 1'b0;
        endcase

        w_misaligned = ((w_size == SZ_H) && bus.addr[0]) ||
                       ((w_size == SZ_W) && (bus.addr[1:0] != 2'b00));

        case (w_size)
            SZ_B: begin
                w_be    = 4'b0001 << bus.addr[1:0];
                w_wdata = {4{bus.store_data[7:0]}};
            end
            SZ_H: begin
                w_be    = bus.addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{bus.store_data[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = bus.store_data;
            end
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] r_cnt;
    logic       r_bus_err;
`endif

    // NOTE: reset is synchronous here, so it lives inside the clocked branch, not the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_be    <= '0;
            r_dmem_wdata <= '0;
            r_load_data  <= '0;
            r_done       <= 1'b0;
            r_misalign   <= 1'b0;
            r_off        <= '0;
            r_is_load    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            r_cnt        <= '0;
            r_bus_err    <= 1'b0;
`endif
        end else begin
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            r_bus_err  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (bus.mem_valid && w_is_mem) begin
                        if (w_misaligned) begin
                            r_misalign <= 1'b1;
                        end else begin
                            r_off        <= bus.addr[1:0];
                            r_is_load    <= ~w_is_store;
                            r_dmem_we    <= w_is_store;
                            r_dmem_addr  <= {bus.addr[31:2], 2'b00};
                            r_dmem_be    <= w_be;
                            r_dmem_wdata <= w_wdata;
                            r_dmem_req   <= 1'b1;
                            r_state      <= S_REQ;
`ifdef LSU_TIMEOUT_EN
                            r_cnt        <= '0;
`endif
                        end
                    end
                end
                S_REQ: begin
                    if (bus.dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= S_DONE;
                        if (r_is_load)
                            r_load_data <= bus.dmem_rdata >> {r_off, 3'b000};
                    end
`ifdef LSU_TIMEOUT_EN
                    // Ack is tested first, so a late ack on the timeout cycle still completes normally.
                    else if (r_cnt == TO_LAST) begin
                        r_dmem_req  <= 1'b0;
                        r_done      <= 1'b1;
                        r_bus_err   <= 1'b1;
                        r_load_data <= '0;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.dmem_req   = r_dmem_req;
    assign bus.dmem_we    = r_dmem_we;
    assign bus.dmem_addr  = r_dmem_addr;
    assign bus.dmem_be    = r_dmem_be;
    assign bus.dmem_wdata = r_dmem_wdata;
    assign bus.load_data  = r_load_data;
    assign bus.done       = r_done;
    assign bus.misalign   = r_misalign;
    assign bus.stall      = bus.mem_valid & w_is_mem & (r_state != S_DONE);
`ifdef LSU_TIMEOUT_EN
    assign bus.bus_err    = r_bus_err;
`else
    assign bus.bus_err    = 1'b0;
`endif
endmodule
